// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send inhibit, 11-bit frame shifted on device clock edges, ack check.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned INHIBIT_CYC = CLK_HZ / 10000,
    parameter int unsigned TIMEOUT_CYC = CLK_HZ / 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned IW = $clog2(INHIBIT_CYC + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYC - 1);

    if (INHIBIT_CYC < 2) begin : g_bad_inhibit
        $error("ps2_host_tx: INHIBIT_CYC must be at least 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("ps2_host_tx: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t         state_q, state_d;
    logic [10:0]    frame_q, frame_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]  inh_cnt_q, inh_cnt_d;
    logic           ack_ok_q, ack_ok_d;

    logic [1:0]     clk_sync_q, data_sync_q;
    logic           clk_prev_q;
    logic           clk_s, data_s, fall, lines_idle;
    logic           timeout;

    assign clk_s      = clk_sync_q[1];
    assign data_s     = data_sync_q[1];
    assign fall       = clk_prev_q & ~clk_s;
    assign lines_idle = clk_s & data_s;

    // Synchronizers reset to the released (high) line level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYC);

    logic [WW-1:0] wd_q, wd_d;
    logic          wd_active;

    assign wd_active = (state_q == START) || (state_q == SHIFT) ||
                       (state_q == ACK)   || (state_q == WAIT_IDLE);
    assign timeout   = wd_active && (wd_q == WD_LIMIT);

    always_comb begin
        wd_d = '0;
        if (wd_active && !timeout) begin
            wd_d = fall ? '0 : wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q   <= '1;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            ack_ok_q  <= 1'b0;
        end else begin
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            ack_ok_q  <= ack_ok_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        ack_ok_d  = ack_ok_q;
        unique case (state_q)
            IDLE: begin
                inh_cnt_d = '0;
                bit_cnt_d = '0;
                if (tx_start) begin
                    // Frame index k holds the bit presented after falling edge k; index 0 is the start bit
                    frame_d = {1'b1, ~^tx_data, tx_data, 1'b0};
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    state_d = START;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            START: begin
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (fall) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    ack_ok_d = ~data_s;
                    state_d  = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (lines_idle) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx_busy     = (state_q != IDLE);
        tx_done     = 1'b0;
        tx_err      = timeout;
        unique case (state_q)
            INHIBIT: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = (inh_cnt_q == INH_LAST);
            end
            START: begin
                ps2_data_oe = ~timeout;
            end
            SHIFT: begin
                ps2_data_oe = ~frame_q[bit_cnt_q] & ~timeout;
            end
            WAIT_IDLE: begin
                if (lines_idle && !timeout) begin
                    tx_done = ack_ok_q;
                    tx_err  = ~ack_ok_q;
                end
            end
            default: begin
                ps2_clk_oe  = 1'b0;
                ps2_data_oe = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model driving open-drain lines.
module tb_ps2_host_tx;

    localparam int INH = 50;
    localparam int TO  = 3000;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_err;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int total = 0;
    int bad = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, long_cnt = 0;
    int inh_events = 0, inh_run = 0, inh_dl = 0, last_inh = 0, last_dl = 0;
    logic prev_done = 1'b0, prev_err = 1'b0;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_HZ(100000000),
        .INHIBIT_CYC(INH),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_err(tx_err),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    // Pulse and inhibit bookkeeping
    always @(negedge clk) begin
        prev_done <= tx_done;
        prev_err  <= tx_err;
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err) err_cnt <= err_cnt + 1;
        if (tx_done && tx_err) both_cnt <= both_cnt + 1;
        if ((tx_done && prev_done) || (tx_err && prev_err)) long_cnt <= long_cnt + 1;
        if (ps2_clk_oe) begin
            inh_run <= inh_run + 1;
            if (ps2_data_oe) inh_dl <= inh_dl + 1;
        end else if (inh_run != 0) begin
            last_inh   <= inh_run;
            last_dl    <= inh_dl;
            inh_run    <= 0;
            inh_dl     <= 0;
            inh_events <= inh_events + 1;
        end
    end

    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        int   ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        par = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic dev_frame(input bit ack, output logic [10:0] got, output bit ok);
        int ev;
        int n;
        ev = inh_events;
        n = 0;
        got = '0;
        ok = 1'b1;
        while (inh_events == ev && n < 4 * INH) begin
            @(negedge clk);
            n++;
        end
        if (inh_events == ev) begin
            ok = 1'b0;
            return;
        end
        repeat (2) @(negedge clk);
        got[0] = ps2_data_in;
        for (int i = 1; i <= 10; i++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            got[i] = ps2_data_in;
            dev_clk = 1'b1;
            repeat (H) @(negedge clk);
        end
        dev_data = ack ? 1'b0 : 1'b1;
        repeat (H) @(negedge clk);
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=00000",
                     {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({ps2_clk_oe, ps2_data_oe, tx_busy} !== 3'b0) begin
            bad++;
            $display("FAIL idle_after_reset got=%b want=000", {ps2_clk_oe, ps2_data_oe, tx_busy});
        end
    endtask

    task automatic test_ed;
        logic [10:0] got;
        bit ok;
        int d0, e0, n;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hED);
        total++;
        if (tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL ed_busy_after_accept got=%b want=1", tx_busy);
        end
        dev_frame(1'b1, got, ok);
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        total++;
        if (ok !== 1'b1 || last_inh != INH) begin
            bad++;
            $display("FAIL ed_inhibit_len got=%0d want=%0d", last_inh, INH);
        end
        total++;
        if (last_dl != 1) begin
            bad++;
            $display("FAIL ed_inhibit_data_low got=%0d want=1", last_dl);
        end
        total++;
        if (got !== 11'b11_1110_1101_0) begin
            bad++;
            $display("FAIL ed_frame got=%b want=%b", got, 11'b11_1110_1101_0);
        end
        total++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin
            bad++;
            $display("FAIL ed_done done=%0d err=%0d want done=1 err=0", done_cnt - d0, err_cnt - e0);
        end
        total++;
        if ({tx_busy, ps2_clk_oe, ps2_data_oe} !== 3'b0) begin
            bad++;
            $display("FAIL ed_idle_after got=%b want=000", {tx_busy, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_random;
        logic [10:0] got;
        logic [7:0]  d;
        bit ok;
        int d0, e0, n, c;
        for (int t = 0; t < 6; t++) begin
            d = (t == 0) ? 8'h01 : (t == 1) ? 8'hFF : 8'($urandom);
            d0 = done_cnt;
            e0 = err_cnt;
            start_tx(d);
            dev_frame(1'b1, got, ok);
            n = 0;
            while (done_cnt == d0 && err_cnt == e0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            repeat (2) @(negedge clk);
            total++;
            if (ok !== 1'b1 || got !== ref_frame(d)) begin
                bad++;
                $display("FAIL rand_frame data=%h got=%b want=%b", d, got, ref_frame(d));
            end
            c = 0;
            for (int i = 1; i <= 9; i++) c += int'(got[i]);
            total++;
            if (c % 2 != 1) begin
                bad++;
                $display("FAIL rand_parity data=%h ones=%0d want odd", d, c);
            end
            total++;
            if (done_cnt - d0 != 1 || err_cnt != e0) begin
                bad++;
                $display("FAIL rand_done data=%h done=%0d err=%0d want 1/0", d, done_cnt - d0, err_cnt - e0);
            end
        end
    endtask

    task automatic test_nack;
        logic [10:0] got;
        bit ok;
        int d0, e0, n;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hF4);
        dev_frame(1'b0, got, ok);
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        total++;
        if (ok !== 1'b1 || err_cnt - e0 != 1 || done_cnt != d0) begin
            bad++;
            $display("FAIL nack_err err=%0d done=%0d want 1/0", err_cnt - e0, done_cnt - d0);
        end
        total++;
        if ({tx_busy, ps2_clk_oe, ps2_data_oe} !== 3'b0) begin
            bad++;
            $display("FAIL nack_release got=%b want=000", {tx_busy, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_back_to_back;
        logic [10:0] got;
        bit ok;
        int d0, e0, n, ev, k;
        d0 = done_cnt;
        e0 = err_cnt;
        fork
            begin
                start_tx(8'hED);
                dev_frame(1'b1, got, ok);
            end
            begin
                ev = inh_events;
                k = 0;
                while (inh_events == ev && k < 500) begin
                    @(negedge clk);
                    k++;
                end
                repeat (3 * H) @(negedge clk);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ev = inh_events;
        repeat (300) @(negedge clk);
        total++;
        if (ok !== 1'b1 || got !== ref_frame(8'hED)) begin
            bad++;
            $display("FAIL restart_frame got=%b want=%b", got, ref_frame(8'hED));
        end
        total++;
        if (done_cnt - d0 != 1 || inh_events != ev || tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL restart_ignored done=%0d new_inhibits=%0d busy=%b want 1/0/0",
                     done_cnt - d0, inh_events - ev, tx_busy);
        end
    endtask

    task automatic test_reset_mid;
        logic [10:0] got;
        bit ok;
        int d0, e0, n, ev;
        d0 = done_cnt;
        e0 = err_cnt;
        ev = inh_events;
        start_tx(8'h3C);
        n = 0;
        while (inh_events == ev && n < 500) begin
            @(negedge clk);
            n++;
        end
        for (int i = 1; i <= 3; i++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            repeat (H) @(negedge clk);
        end
        dev_clk = 1'b0;
        repeat (H / 2) @(negedge clk);
        total++;
        if (tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL midreset_precond busy=%b want=1", tx_busy);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err} !== 5'b0) begin
            bad++;
            $display("FAIL midreset_async got=%b want=00000",
                     {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err});
        end
        @(negedge clk);
        dev_clk = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (done_cnt != d0 || err_cnt != e0) begin
            bad++;
            $display("FAIL midreset_no_pulse done=%0d err=%0d want 0/0", done_cnt - d0, err_cnt - e0);
        end
        start_tx(8'hF4);
        dev_frame(1'b1, got, ok);
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        total++;
        if (ok !== 1'b1 || got !== ref_frame(8'hF4) || done_cnt - d0 != 1 || err_cnt != e0) begin
            bad++;
            $display("FAIL midreset_recover frame=%b want=%b done=%0d err=%0d",
                     got, ref_frame(8'hF4), done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_no_clock;
        int n, e0;
        e0 = err_cnt;
        start_tx(8'hA5);
        n = 0;
        while (ps2_clk_oe && n < 4 * INH) begin
            @(negedge clk);
            n++;
        end
        n = 0;
`ifdef PS2_TX_TIMEOUT_EN
        while (!tx_err && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != TO) begin
            bad++;
            $display("FAIL timeout_latency got=%0d want=%0d", n, TO);
        end
        total++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b0) begin
            bad++;
            $display("FAIL timeout_release got=%b want=00", {ps2_clk_oe, ps2_data_oe});
        end
        @(negedge clk);
        total++;
        if (tx_busy !== 1'b0 || err_cnt - e0 != 1) begin
            bad++;
            $display("FAIL timeout_idle busy=%b err=%0d want 0/1", tx_busy, err_cnt - e0);
        end
`else
        repeat (TO + 500) @(negedge clk);
        total++;
        if (tx_busy !== 1'b1 || err_cnt != e0 || ps2_data_oe !== 1'b1) begin
            bad++;
            $display("FAIL no_watchdog_wait busy=%b err=%0d data_oe=%b want 1/0/1",
                     tx_busy, err_cnt - e0, ps2_data_oe);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
`endif
    endtask

    initial begin
        test_reset();
        test_ed();
        test_random();
        test_nack();
        test_back_to_back();
        test_reset_mid();
        test_no_clock();
        total++;
        if (both_cnt != 0 || long_cnt != 0) begin
            bad++;
            $display("FAIL pulse_shape overlap=%0d long=%0d want 0/0", both_cnt, long_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
